// File: rtl/multi_timer.sv
`default_nettype none
// ============================================================================
// Module      : multi_timer
// Description : Bus timer with NR_CHANNELS down-counting channels sharing one
//               programmable prescaler, sticky IRQ status and one masked IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_timer #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int NR_CHANNELS     = 4,
    parameter int PRESCALER_WIDTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      timer_req_i,
    input  logic                      timer_we_i,
    input  logic [DATA_WIDTH/8-1:0]   timer_be_i,
    input  logic [ADDRESS_WIDTH-1:0]  timer_addr_i,
    input  logic [DATA_WIDTH-1:0]     timer_wdata_i,
    output logic                      timer_rvalid_o,
    output logic [DATA_WIDTH-1:0]     timer_rdata_o,
    output logic                      timer_err_o,
    output logic                      timer_intr_o
);

    localparam int         c_nbytes = DATA_WIDTH / 8;
    localparam logic [5:0] c_nch    = 6'(NR_CHANNELS);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} ch_state_e;

    // Address decode: word index splits into a 16-byte group and a sub-register.
    logic [7:0] w_word;
    logic [5:0] w_grp, w_ch;
    logic [1:0] w_sub;
    logic       w_is_glb, w_ch_ok, w_bad_mode, w_err, w_wr, w_rd;
    logic       w_unused_addr;

    assign w_word        = timer_addr_i[9:2];
    assign w_grp         = w_word[7:2];
    assign w_sub         = w_word[1:0];
    assign w_ch          = w_grp - 6'd1;
    assign w_is_glb      = (w_grp == 6'd0);
    assign w_ch_ok       = !w_is_glb && (w_ch < c_nch);
    assign w_bad_mode    = timer_we_i && timer_be_i[0] && (timer_wdata_i[1:0] == 2'b11) && (w_sub == 2'd2);
    assign w_err         = !w_is_glb && (!w_ch_ok || (w_sub == 2'd3) || w_bad_mode);
    assign w_wr          = timer_req_i && timer_we_i && !w_err;
    assign w_rd          = timer_req_i && !timer_we_i && !w_err;
    assign w_unused_addr = ^{timer_addr_i[ADDRESS_WIDTH-1:10], timer_addr_i[1:0]};

    logic [DATA_WIDTH-1:0] w_bmask, w_wdat_m;
    for (genvar b = 0; b < c_nbytes; b++) begin : g_bmask
        assign w_bmask[8*b +: 8] = {8{timer_be_i[b]}};
    end
    assign w_wdat_m = timer_wdata_i & w_bmask;

    logic                       r_en, r_intr, r_rvalid, r_err;
    logic [PRESCALER_WIDTH-1:0] r_prescale, r_pcnt;
    logic [NR_CHANNELS-1:0]     r_status, r_enable, w_set, w_clr;
    logic [DATA_WIDTH-1:0]      r_rdata, w_rdata;
    logic                       w_tick;

    assign w_tick = r_en && (r_pcnt == r_prescale);
    assign w_clr  = (w_wr && w_is_glb && (w_sub == 2'd2)) ? w_wdat_m[NR_CHANNELS-1:0] : '0;

    logic [DATA_WIDTH-1:0] w_load_v  [NR_CHANNELS];
    logic [DATA_WIDTH-1:0] w_count_v [NR_CHANNELS];
    logic [1:0]            w_mode_v  [NR_CHANNELS];

    for (genvar n = 0; n < NR_CHANNELS; n++) begin : g_ch
        ch_state_e             r_state, w_state_d;
        logic [DATA_WIDTH-1:0] r_load, r_count, w_count_d;
        logic [1:0]            r_mode, w_mode_d;
        logic                  w_sel, w_cfg_wr, w_load_wr, w_expire;

        assign w_sel     = w_wr && !w_is_glb && (w_ch == 6'(n));
        assign w_cfg_wr  = w_sel && (w_sub == 2'd2) && timer_be_i[0];
        assign w_load_wr = w_sel && (w_sub == 2'd0);

        // A CFG write restarts the channel and takes priority over a same-cycle tick.
        always_comb begin
            w_state_d = r_state;
            w_count_d = r_count;
            w_mode_d  = r_mode;
            w_expire  = 1'b0;
            if (w_cfg_wr) begin
                w_mode_d = timer_wdata_i[1:0];
                if (timer_wdata_i[1:0] != 2'b00) begin
                    w_count_d = r_load;
                    w_state_d = S_RUN;
                end else begin
                    w_state_d = S_IDLE;
                end
            end else if (r_state == S_RUN && w_tick) begin
                if (r_count != '0) begin
                    w_count_d = r_count - 1'b1;
                end else begin
                    w_expire = 1'b1;
                    if (r_mode == 2'd2) begin
                        w_count_d = r_load;
                    end else begin
                        w_mode_d  = 2'd0;
                        w_state_d = S_IDLE;
                    end
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_state <= S_IDLE;
                r_load  <= '0;
                r_count <= '0;
                r_mode  <= 2'd0;
            end else begin
                r_state <= w_state_d;
                r_count <= w_count_d;
                r_mode  <= w_mode_d;
                if (w_load_wr) r_load <= (r_load & ~w_bmask) | w_wdat_m;
            end
        end

        assign w_set[n]     = w_expire;
        assign w_load_v[n]  = r_load;
        assign w_count_v[n] = r_count;
        assign w_mode_v[n]  = r_mode;
    end

    always_comb begin
        w_rdata = '0;
        if (w_is_glb) begin
            case (w_sub)
                2'd0:    w_rdata[0] = r_en;
                2'd1:    w_rdata[PRESCALER_WIDTH-1:0] = r_prescale;
                2'd2:    w_rdata[NR_CHANNELS-1:0] = r_status;
                default: w_rdata[NR_CHANNELS-1:0] = r_enable;
            endcase
        end else begin
            for (int i = 0; i < NR_CHANNELS; i++) begin
                if (w_ch == 6'(i)) begin
                    case (w_sub)
                        2'd0:    w_rdata = w_load_v[i];
                        2'd1:    w_rdata = w_count_v[i];
                        2'd2:    w_rdata[1:0] = w_mode_v[i];
                        default: w_rdata = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_en       <= 1'b0;
            r_prescale <= '0;
            r_pcnt     <= '0;
            r_status   <= '0;
            r_enable   <= '0;
            r_intr     <= 1'b0;
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (w_wr && w_is_glb && (w_sub == 2'd0) && timer_be_i[0]) r_en <= timer_wdata_i[0];
            if (w_wr && w_is_glb && (w_sub == 2'd1)) begin
                r_prescale <= (r_prescale & ~w_bmask[PRESCALER_WIDTH-1:0]) | w_wdat_m[PRESCALER_WIDTH-1:0];
                r_pcnt     <= '0;
            end else if (r_en) begin
                r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
            end
            // Hardware set is OR-ed after the clear so a coincident expiry wins.
            r_status <= (r_status & ~w_clr) | w_set;
            if (w_wr && w_is_glb && (w_sub == 2'd3))
                r_enable <= (r_enable & ~w_bmask[NR_CHANNELS-1:0]) | w_wdat_m[NR_CHANNELS-1:0];
            r_intr   <= |(r_status & r_enable);
            r_rvalid <= timer_req_i;
            r_err    <= timer_req_i && w_err;
            r_rdata  <= w_rd ? w_rdata : '0;
        end
    end

    assign timer_rvalid_o = r_rvalid;
    assign timer_rdata_o  = r_rdata;
    assign timer_err_o    = r_err;
    assign timer_intr_o   = r_intr;

endmodule
`default_nettype wire

// File: tb/tb_multi_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_timer
// Description : Scoreboard bench for multi_timer against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_timer;

    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        timer_req_i = 1'b0;
    logic        timer_we_i = 1'b0;
    logic [3:0]  timer_be_i = 4'h0;
    logic [31:0] timer_addr_i = '0;
    logic [31:0] timer_wdata_i = '0;
    logic        timer_rvalid_o;
    logic [31:0] timer_rdata_o;
    logic        timer_err_o;
    logic        timer_intr_o;

    multi_timer #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .NR_CHANNELS(NC), .PRESCALER_WIDTH(16)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .timer_req_i(timer_req_i), .timer_we_i(timer_we_i),
        .timer_be_i(timer_be_i), .timer_addr_i(timer_addr_i), .timer_wdata_i(timer_wdata_i),
        .timer_rvalid_o(timer_rvalid_o), .timer_rdata_o(timer_rdata_o),
        .timer_err_o(timer_err_o), .timer_intr_o(timer_intr_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    // Expected bus responses: {err, rdata}.
    logic [32:0] exp_q[$];

    // Behavioural model state.
    bit          m_en;
    logic [15:0] m_prescale, m_pcnt;
    logic [3:0]  m_status, m_enable;
    logic [31:0] m_load [NC];
    logic [31:0] m_count[NC];
    int          m_mode [NC];
    bit          m_run  [NC];
    bit          m_intr, m_rvalid;

    task automatic model_reset();
        m_en = 0; m_prescale = 0; m_pcnt = 0; m_status = 0; m_enable = 0;
        m_intr = 0; m_rvalid = 0;
        for (int c = 0; c < NC; c++) begin
            m_load[c] = 0; m_count[c] = 0; m_mode[c] = 0; m_run[c] = 0;
        end
    endtask

    function automatic bit mapped(input logic [31:0] a, output int c, output int sub);
        int off;
        off = int'(a[9:0]) & 'h3FC;
        if (off < 'h10) begin
            c = -1; sub = off / 4;
            return 1'b1;
        end
        c = (off - 'h10) / 16;
        sub = ((off - 'h10) % 16) / 4;
        return (c < NC) && (sub != 3);
    endfunction

    function automatic bit is_err(input bit we, input logic [3:0] be, input logic [31:0] a,
                                  input logic [31:0] wd);
        int c, sub;
        bit ok;
        ok = mapped(a, c, sub);
        return !ok || (we && c >= 0 && sub == 2 && be[0] && wd[1:0] == 2'd3);
    endfunction

    function automatic logic [32:0] exp_resp(input bit we, input logic [3:0] be,
                                             input logic [31:0] a, input logic [31:0] wd);
        int c, sub;
        bit ok;
        logic [31:0] v;
        if (is_err(we, be, a, wd)) return {1'b1, 32'h0};
        if (we) return {1'b0, 32'h0};
        ok = mapped(a, c, sub);
        v = 0;
        if (c < 0) begin
            case (sub)
                0: v = 32'(m_en);
                1: v = 32'(m_prescale);
                2: v = 32'(m_status);
                default: v = 32'(m_enable);
            endcase
        end else begin
            case (sub)
                0: v = m_load[c];
                1: v = m_count[c];
                default: v = 32'(m_mode[c]);
            endcase
        end
        return {1'b0, v};
    endfunction

    // Advances the model across one rising edge given that cycle's bus inputs.
    task automatic model_edge(input bit r, input bit req, input bit we, input logic [3:0] be,
                              input logic [31:0] a, input logic [31:0] wd);
        bit tick, wr;
        logic [3:0] set, clr;
        logic [31:0] bm;
        int c, sub;
        bit ok;
        if (r) begin
            model_reset();
            return;
        end
        for (int b = 0; b < 4; b++) bm[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
        ok = mapped(a, c, sub);
        wr = req && we && !is_err(we, be, a, wd);
        tick = m_en && (m_pcnt == m_prescale);
        set = 0;
        clr = 0;
        for (int k = 0; k < NC; k++) begin
            if (wr && c == k && sub == 2 && be[0]) begin
                m_mode[k] = int'(wd[1:0]);
                m_run[k]  = (wd[1:0] != 0);
                if (m_run[k]) m_count[k] = m_load[k];
            end else if (m_run[k] && tick) begin
                if (m_count[k] > 0) m_count[k] = m_count[k] - 1;
                else begin
                    set[k] = 1'b1;
                    if (m_mode[k] == 2) m_count[k] = m_load[k];
                    else begin m_mode[k] = 0; m_run[k] = 0; end
                end
            end
        end
        if (wr && c == -1 && sub == 1) m_pcnt = 0;
        else if (m_en) m_pcnt = tick ? 16'd0 : m_pcnt + 16'd1;
        m_intr = |(m_status & m_enable);
        if (wr && c == -1 && sub == 2) clr = wd[3:0] & bm[3:0];
        m_status = (m_status & ~clr) | set;
        if (wr && c == -1 && sub == 0 && be[0]) m_en = wd[0];
        if (wr && c == -1 && sub == 1) m_prescale = (m_prescale & ~bm[15:0]) | (wd[15:0] & bm[15:0]);
        if (wr && c == -1 && sub == 3) m_enable = (m_enable & ~bm[3:0]) | (wd[3:0] & bm[3:0]);
        if (wr && c >= 0 && sub == 0) m_load[c] = (m_load[c] & ~bm) | (wd & bm);
        m_rvalid = req;
    endtask

    task automatic cyc(input bit r, input bit rq, input bit we, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] wd);
        rst_i = r; timer_req_i = rq; timer_we_i = we; timer_be_i = be;
        timer_addr_i = a; timer_wdata_i = wd;
        if (rq && !r) exp_q.push_back(exp_resp(we, be, a, wd));
        @(posedge clk);
        model_edge(r, rq, we, be, a, wd);
        #1;
        rst_i = 0; timer_req_i = 0; timer_we_i = 0; timer_be_i = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd);
        cyc(0, 1, 1, 4'hF, a, wd);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(0, 1, 0, 4'h0, a, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    // Monitor: compares the DUT outputs against the model and scoreboard each cycle.
    always @(negedge clk) begin
        if (started) begin
            logic [32:0] e;
            checks++;
            if (timer_intr_o !== m_intr) begin
                errors++;
                $display("FAIL intr at %0t: got %b expected %b", $time, timer_intr_o, m_intr);
            end
            checks++;
            if (timer_rvalid_o !== m_rvalid) begin
                errors++;
                $display("FAIL rvalid at %0t: got %b expected %b", $time, timer_rvalid_o, m_rvalid);
            end
            if (timer_rvalid_o === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rvalid at %0t: got rvalid=1 expected no response", $time);
                end else begin
                    e = exp_q.pop_front();
                    if ({timer_err_o, timer_rdata_o} !== e) begin
                        errors++;
                        $display("FAIL resp at %0t: got err=%b rdata=%h expected err=%b rdata=%h",
                                 $time, timer_err_o, timer_rdata_o, e[32], e[31:0]);
                    end
                end
            end else begin
                checks++;
                if (timer_rdata_o !== 32'h0) begin
                    errors++;
                    $display("FAIL idle_rdata at %0t: got %h expected 0", $time, timer_rdata_o);
                end
            end
        end
    end

    initial begin
        model_reset();
        cyc(1, 0, 0, 0, 0, 0);
        started = 1'b1;
        cyc(1, 0, 0, 0, 0, 0);

        // Periodic channel 0 with prescaler, interrupt, then W1C.
        wr(32'h04, 3); wr(32'h00, 1); wr(32'h10, 4); wr(32'h0C, 1); wr(32'h18, 2);
        idle(45); wr(32'h08, 1); idle(5); rd(32'h08);

        // One-shot channel 1 at full tick rate.
        wr(32'h18, 0); wr(32'h04, 0); wr(32'h20, 2); wr(32'h28, 1); wr(32'h0C, 3);
        idle(10); rd(32'h28); rd(32'h24); rd(32'h08); wr(32'h08, 3); idle(6);

        // W1C coinciding with an expiry keeps the bit.
        wr(32'h10, 0); wr(32'h18, 2); idle(2); wr(32'h08, 1); rd(32'h08); wr(32'h18, 0);

        // Error paths leave state untouched.
        rd(32'h3F0); wr(32'h28, 3); rd(32'h28); rd(32'h04); wr(32'h5C, 1); rd(32'h54);

        // Partial byte enables, then freeze on EN clear.
        cyc(0, 1, 1, 4'b0011, 32'h40, 32'hAABBCCDD); rd(32'h40);
        wr(32'h40, 50); wr(32'h04, 1); wr(32'h48, 2); idle(20);
        wr(32'h00, 0); rd(32'h44); idle(100); rd(32'h44); wr(32'h00, 1); idle(4);

        // Reset mid-run aborts everything.
        idle(1); cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);
        rd(32'h44); rd(32'h48); rd(32'h00);

        // Randomized traffic.
        for (int it = 0; it < 1500; it++) begin
            int t;
            logic [31:0] hi, a;
            logic [3:0] be;
            hi = $urandom() & 32'hFFFF_FC00;
            be = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
            t = $urandom_range(0, 11);
            case (t)
                0: cyc(0, 1, 1, be, hi | 32'h00, ($urandom_range(0, 4) != 0) ? 32'd1 : 32'd0);
                1: cyc(0, 1, 1, be, hi | 32'h04, $urandom_range(0, 3));
                2: cyc(0, 1, 1, be, hi | 32'h08, $urandom());
                3: cyc(0, 1, 1, be, hi | 32'h0C, $urandom());
                4: cyc(0, 1, 1, be, hi | (32'h10 + 32'h10 * $urandom_range(0, 4)), $urandom_range(0, 6));
                5, 6: cyc(0, 1, 1, be, hi | (32'h18 + 32'h10 * $urandom_range(0, 4)), $urandom_range(0, 3));
                7, 8: begin
                    a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 19)) * 4 : 32'($urandom_range(0, 255)) * 4;
                    rd(hi | a | 32'($urandom_range(0, 3)));
                end
                9: cyc(0, 1, 1, be, hi | 32'($urandom_range(0, 255)) * 4, $urandom());
                default: idle($urandom_range(1, 6));
            endcase
            if (it == 750) begin
                cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);
            end
        end

        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_responses: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
